// File: rtl/serializer_pkg.sv
// Shared state encoding and sizing helpers for the flit serializer.
// The PARITY state exists only when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   function automatic int beatCount(input int inWidth, input int outWidth, input bit parityEn);
      return (inWidth / outWidth) + (parityEn ? 1 : 0);
   endfunction

   function automatic int counterWidth(input int inWidth, input int outWidth);
      return $clog2((inWidth / outWidth) + 2);
   endfunction

endpackage

// File: rtl/param_piso_shift_register.sv
// Parallel-in, serial-out shift register: load has priority over shift,
// and the outgoing beat is taken from the MSB or LSB end depending on MSB_FIRST.
module param_piso_shift_register #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic                 shift_i,
   input  logic [IN_WIDTH-1:0]  data_i,
   output logic [OUT_WIDTH-1:0] beat_o
);

   logic [IN_WIDTH-1:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (load_i) begin
         shreg_d = data_i;
      end else if (shift_i) begin
         shreg_d = MSB_FIRST ? (shreg_q << OUT_WIDTH) : (shreg_q >> OUT_WIDTH);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign beat_o = MSB_FIRST ? shreg_q[IN_WIDTH-1 -: OUT_WIDTH] : shreg_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/flit_serializer.sv
// Pops words from a show-ahead FIFO and emits them as OUT_WIDTH beats with
// valid/ready handshaking; SERIALIZER_PARITY_EN appends an XOR parity beat.
module flit_serializer
   import serializer_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_empty,
   input  logic [IN_WIDTH-1:0]  data_in,
   output logic                 read_fifo,
   output logic [OUT_WIDTH-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 data_last,
   output logic                 serializer_idle
);

   localparam int NBEATS = beatCount(IN_WIDTH, OUT_WIDTH, 1'b0);
   localparam int CW     = counterWidth(IN_WIDTH, OUT_WIDTH);
   localparam logic [CW-1:0] LAST_DATA = CW'(NBEATS - 1);

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [OUT_WIDTH-1:0] beat;
   logic                 transfer;
   logic                 finalBeat;
   logic                 loadWord;
   logic                 shiftEn;

   param_piso_shift_register #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_piso (
      .clk     (clk),
      .reset   (reset),
      .load_i  (loadWord),
      .shift_i (shiftEn),
      .data_i  (data_in),
      .beat_o  (beat)
   );

   assign data_valid      = (state_q != IDLE);
   assign serializer_idle = (state_q == IDLE);
   assign transfer        = data_valid && data_ready;
`ifdef SERIALIZER_PARITY_EN
   assign finalBeat = (state_q == PARITY);
`else
   assign finalBeat = (state_q == SHIFT) && (count_q == LAST_DATA);
`endif
   assign data_last = finalBeat;
   // Gating with reset keeps the FIFO untouched while reset is held.
   assign loadWord  = reset && !fifo_empty && ((state_q == IDLE) || (transfer && finalBeat));
   assign read_fifo = loadWord;
   assign shiftEn   = transfer && (state_q == SHIFT);

`ifdef SERIALIZER_PARITY_EN
   logic [OUT_WIDTH-1:0] parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (loadWord) begin
         parity_d = '0;
      end else if (shiftEn) begin
         parity_d = parity_q ^ beat;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         parity_q <= '0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign data_out = !data_valid ? '0 : ((state_q == PARITY) ? parity_q : beat);
`else
   assign data_out = data_valid ? beat : '0;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (loadWord) begin
               state_d = SHIFT;
               count_d = '0;
            end
         end
         SHIFT: begin
            if (transfer) begin
               if (count_q == LAST_DATA) begin
`ifdef SERIALIZER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = loadWord ? SHIFT : IDLE;
`endif
                  count_d = '0;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: begin
            if (transfer) begin
               state_d = loadWord ? SHIFT : IDLE;
               count_d = '0;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_flit_serializer.sv
// Randomized bench for flit_serializer: MSB-first and LSB-first instances share one
// FIFO model and are compared against a beat-queue reference model.
module tb_flit_serializer;

   localparam int IW = 32;
   localparam int OW = 4;
   localparam int NB = IW / OW;
`ifdef SERIALIZER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct {
      logic [OW-1:0] beat;
      bit            last;
   } beat_t;

   logic          clk = 1'b0;
   logic          resetN;
   logic          fifoEmpty;
   logic [IW-1:0] dataIn;
   logic          dataReady;

   logic          rdMsb, validMsb, lastMsb, idleMsb;
   logic [OW-1:0] doutMsb;
   logic          rdLsb, validLsb, lastLsb, idleLsb;
   logic [OW-1:0] doutLsb;

   logic [IW-1:0] fifoQ[$];
   beat_t         expMsb[$];
   beat_t         expLsb[$];

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   flit_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) dut (
      .clk             (clk),
      .reset           (resetN),
      .fifo_empty      (fifoEmpty),
      .data_in         (dataIn),
      .read_fifo       (rdMsb),
      .data_out        (doutMsb),
      .data_valid      (validMsb),
      .data_ready      (dataReady),
      .data_last       (lastMsb),
      .serializer_idle (idleMsb)
   );

   flit_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) dutLsb (
      .clk             (clk),
      .reset           (resetN),
      .fifo_empty      (fifoEmpty),
      .data_in         (dataIn),
      .read_fifo       (rdLsb),
      .data_out        (doutLsb),
      .data_valid      (validLsb),
      .data_ready      (dataReady),
      .data_last       (lastLsb),
      .serializer_idle (idleLsb)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Expected beats come from slicing the word arithmetically in each order.
   task automatic pushWord(input logic [IW-1:0] w);
      logic [OW-1:0] bm, bl, par;
      par = '0;
      for (int i = 0; i < NB; i++) begin
         bm = OW'(w >> (IW - (i + 1) * OW));
         bl = OW'(w >> (i * OW));
         par ^= bm;
         expMsb.push_back('{beat: bm, last: (!PAR && i == NB - 1)});
         expLsb.push_back('{beat: bl, last: (!PAR && i == NB - 1)});
      end
      if (PAR) begin
         expMsb.push_back('{beat: par, last: 1'b1});
         expLsb.push_back('{beat: par, last: 1'b1});
      end
   endtask

   task automatic checkSide(input string side, input logic [OW-1:0] dout, input logic valid,
                            input logic last, input logic idle, input beat_t exp[$]);
      bit busy;
      busy = (exp.size() != 0);
      checkOutput({side, "_valid"}, 32'(valid), 32'(busy));
      checkOutput({side, "_idle"}, 32'(idle), 32'(!busy));
      if (busy) begin
         checkOutput({side, "_data"}, 32'(dout), 32'(exp[0].beat));
         checkOutput({side, "_last"}, 32'(last), 32'(exp[0].last));
      end else begin
         checkOutput({side, "_data_idle"}, 32'(dout), 32'd0);
         checkOutput({side, "_last_idle"}, 32'(last), 32'd0);
      end
   endtask

   // One clock cycle: drive inputs, check at the falling edge, advance the model after the rising edge.
   task automatic applyStimulus(input logic rdy, input logic rstN);
      bit readExp;
      dataReady = rdy;
      resetN    = rstN;
      fifoEmpty = (fifoQ.size() == 0);
      dataIn    = (fifoQ.size() != 0) ? fifoQ[0] : IW'($urandom);
      @(negedge clk);
      readExp = rstN && (fifoQ.size() != 0) &&
                ((expMsb.size() == 0) || (expMsb.size() == 1 && rdy));
      checkOutput("read_fifo_msb", 32'(rdMsb), 32'(readExp));
      checkOutput("read_fifo_lsb", 32'(rdLsb), 32'(readExp));
      checkSide("msb", doutMsb, validMsb, lastMsb, idleMsb, expMsb);
      checkSide("lsb", doutLsb, validLsb, lastLsb, idleLsb, expLsb);
      if (rstN && rdy && expMsb.size() != 0) begin
         void'(expMsb.pop_front());
         void'(expLsb.pop_front());
      end
      if (readExp) begin
         pushWord(fifoQ[0]);
      end
      @(posedge clk);
      #1;
      if (readExp) begin
         void'(fifoQ.pop_front());
      end
      if (!rstN) begin
         expMsb.delete();
         expLsb.delete();
      end
   endtask

   initial begin
      resetN    = 1'b0;
      dataReady = 1'b0;
      fifoEmpty = 1'b1;
      dataIn    = '0;
      @(posedge clk);
      #1;

      // Reset held with a word waiting: nothing may be popped.
      fifoQ.push_back(32'h12345678);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1);

      fifoQ.push_back(32'hA5A5A5A5);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1);

      fifoQ.push_back(32'h11111111);
      fifoQ.push_back(32'h22222222);
      for (int i = 0; i < 22; i++) applyStimulus(1'b1, 1'b1);

      // Downstream stall on the third beat.
      fifoQ.push_back(32'h12345678);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);

      // Reset on the fourth beat, with a second word already waiting.
      fifoQ.push_back(32'hCAFEF00D);
      fifoQ.push_back(32'h0BADBEEF);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b1);

      for (int i = 0; i < 500; i++) begin
         if (fifoQ.size() < 6 && $urandom_range(0, 3) == 0) fifoQ.push_back(IW'($urandom));
         applyStimulus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 80) != 0));
      end

      for (int i = 0; i < 150 && (fifoQ.size() != 0 || expMsb.size() != 0); i++) begin
         applyStimulus(1'b1, 1'b1);
      end
      checkOutput("drain_fifo", 32'(fifoQ.size()), 32'd0);
      checkOutput("drain_beats", 32'(expMsb.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/flit_serializer.md
FLIT_SERIALIZER -- requirements
Module: flit_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, width of FIFO word.
REQ-002 SHALL have parameter OUT_WIDTH, default 4, width of one output beat; IN_WIDTH mod OUT_WIDTH SHALL be 0 and IN_WIDTH/OUT_WIDTH >= 2.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = most-significant beat first, 0 = least-significant beat first.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 fifo_empty  input  1  upstream show-ahead FIFO empty flag.
REQ-007 data_in  input  IN_WIDTH  FIFO head word, valid whenever fifo_empty=0.
REQ-008 read_fifo  output  1  pop pulse; head word consumed in the same cycle.
REQ-009 data_out  output  OUT_WIDTH  current beat.
REQ-010 data_valid  output  1  data_out holds a valid beat.
REQ-011 data_ready  input  1  downstream accepts beat; transfer = data_valid & data_ready.
REQ-012 data_last  output  1  current beat is final beat of the word.
REQ-013 serializer_idle  output  1  no word held, nothing in flight.

Function
REQ-014 N = IN_WIDTH/OUT_WIDTH beats per word (N+1 with parity, REQ-027); beat counter width $clog2(N+2).
REQ-015 FSM states: IDLE, SHIFT, PARITY (PARITY only with REQ-027).
REQ-016 IDLE with fifo_empty=0: read_fifo=1 that cycle, word loaded, next state SHIFT; data_valid=1 from the next cycle.
REQ-017 SHIFT: data_out = current beat per MSB_FIRST; shift/counter advance only on transfer; data_out, data_valid held stable while data_ready=0.
REQ-018 Transfer of last data beat: if fifo_empty=0, read_fifo=1 and the next word loads in the same cycle, with no bubble (back-to-back); if fifo_empty=1, return to IDLE.
REQ-019 read_fifo SHALL never assert when fifo_empty=1, and SHALL assert at most once per word.
REQ-020 data_last=1 only on the final beat of a word (data or parity beat), and only while data_valid=1.
REQ-021 serializer_idle=1 only in IDLE; in IDLE, data_valid=0.
REQ-022 fifo_empty changes during SHIFT SHALL not affect the word in flight.

Reset
REQ-023 While reset=0 at a clock edge: state=IDLE, counter=0, shift register=0.
REQ-024 Reset values: data_out=0, data_valid=0, data_last=0, read_fifo=0, serializer_idle=1.
REQ-025 A word in flight at reset mid-operation SHALL be discarded without re-reading the FIFO.
REQ-026 While reset=0, read_fifo SHALL be 0 regardless of fifo_empty.

Configuration
REQ-027 With macro SERIALIZER_PARITY_EN defined: after the last data beat, state PARITY emits one extra beat equal to the XOR of all N data beats, with data_last on it; REQ-018 applies to that beat.
REQ-028 Without SERIALIZER_PARITY_EN: no PARITY state and no parity logic; data_last is on data beat N.

Structure
REQ-029 Package serializer_pkg SHALL hold the state enum typedef and a constant function for beat count and counter width.
REQ-030 Shift register SHALL be one sub-module, param_piso_shift_register (parameters IN_WIDTH, OUT_WIDTH, MSB_FIRST; load, shift enable); the FSM, counter and parity stay in the top.

Verification
REQ-031 Defaults, parity off, data_ready=1, word 0x12345678 -> read_fifo one cycle; beats 1,2,3,4,5,6,7,8 on consecutive cycles; data_last on 8; then idle.
REQ-032 Same word, parity on -> nine beats 1..8 then 0x8; data_last only on 0x8.
REQ-033 MSB_FIRST=0, word 0xA5A5A5A5 -> beats 5,A,5,A,5,A,5,A.
REQ-034 Two words 0x11111111, 0x22222222 queued -> 16 consecutive valid beats; second read_fifo coincides with transfer of beat 8.
REQ-035 data_ready=0 for 3 cycles on beat 3 -> data_out=3 held stable with data_valid=1; beat order is unchanged afterwards.
REQ-036 reset=0 asserted on beat 4 -> next cycle all outputs at reset values; FIFO not re-read until reset=1 and fifo_empty=0.
